// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch instruction queue.
package fetch_pkg;
  typedef enum logic [1:0] {IDLE, FILL, HALT} fetch_q_state_t;

  localparam int INSTR_W     = 32;
  localparam int INSTR_BYTES = 4;
  localparam int BEAT_BYTES  = 8;
  localparam logic [INSTR_W-1:0] HALT_WORD = 32'h0;

  typedef struct packed {
    logic [63:0]        pc;
    logic [INSTR_W-1:0] instr;
  } fq_entry_t;
endpackage

// File: rtl/instr_fifo_2w1r.sv
// Circular instruction buffer: up to two writes and one read per cycle.
module instr_fifo_2w1r
  import fetch_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_clear,
  input  logic                     i_push0,
  input  fq_entry_t                i_ent0,
  input  logic                     i_push1,
  input  fq_entry_t                i_ent1,
  input  logic                     i_pop,
  output fq_entry_t                o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic [$clog2(DEPTH):0]   o_free
);
  localparam int AW = $clog2(DEPTH);

  fq_entry_t        r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [AW:0]      r_count;
  logic [AW-1:0]    w_wr1;

  // The second word lands after the first only when the first was written.
  assign w_wr1   = r_wr_ptr + AW'(i_push0);
  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_free  = (AW+1)'(DEPTH) - r_count;

  always_ff @(posedge i_clk) begin
    if (!i_clear && i_push0) r_mem[r_wr_ptr] <= i_ent0;
    if (!i_clear && i_push1) r_mem[w_wr1]    <= i_ent1;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + AW'(i_push0) + AW'(i_push1);
      r_rd_ptr <= r_rd_ptr + AW'(i_pop);
      r_count  <= r_count + (AW+1)'(i_push0) + (AW+1)'(i_push1) - (AW+1)'(i_pop);
    end
  end
endmodule

// File: rtl/fetch_instr_queue.sv
// Splits 64-bit fetch response beats into PC-tagged instructions for decode,
// and raises a sticky halt when an all-zero word reaches the head.
module fetch_instr_queue
  import fetch_pkg::*;
#(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int DEPTH          = 8,
  parameter int LINE_BEATS     = 8
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_fetch_start,
  input  logic [63:0]               i_fetch_addr,
  input  logic                      i_flush,
  input  logic                      i_bus_respcyc,
  input  logic [BUS_DATA_WIDTH-1:0] i_bus_resp,
  output logic                      o_bus_respack,
  output logic                      o_instr_valid,
  output logic [INSTR_W-1:0]        o_instr,
  output logic [63:0]               o_instr_pc,
  input  logic                      i_decode_ready,
  output logic                      o_line_done,
  output logic                      o_halt
);
  localparam int CW  = $clog2(DEPTH) + 1;
  localparam int BCW = $clog2(LINE_BEATS + 1);

  fetch_q_state_t r_state, w_state_nxt;
  logic [63:0]    r_wr_pc;
  logic           r_skip_low, r_halt, r_line_done, r_out_en;
  logic [BCW-1:0] r_beat_cnt;

  fq_entry_t      w_head, w_ent0, w_ent1;
  logic [CW-1:0]  w_count, w_free;
  logic [CW:0]    w_room, w_need;
  logic           w_nonempty, w_head_zero, w_pop, w_accept, w_last, w_halt_det, w_clear;
  logic           w_unused;

  assign w_unused    = ^i_fetch_addr[1:0];
  assign w_nonempty  = (w_count != '0);
  assign w_head_zero = w_nonempty && (w_head.instr == HALT_WORD);
  assign w_halt_det  = w_head_zero && (r_state != HALT);

  assign o_instr_valid = w_nonempty && !w_head_zero && (r_state != HALT);
  assign o_instr       = o_instr_valid ? w_head.instr : '0;
  assign o_instr_pc    = o_instr_valid ? w_head.pc : '0;
  assign o_line_done   = r_line_done;
  assign o_halt        = r_halt;

  // A concurrent pop frees a slot this same edge, so ack may follow decode_ready.
  assign w_pop  = o_instr_valid && i_decode_ready;
  assign w_room = {1'b0, w_free} + (CW+1)'(w_pop);
  assign w_need = r_skip_low ? (CW+1)'(1) : (CW+1)'(2);

  // Outside FILL every beat is drained; r_out_en masks the first cycle after reset.
  assign o_bus_respack = r_out_en && i_bus_respcyc && ((r_state != FILL) || (w_room >= w_need));
  assign w_accept      = o_bus_respack && (r_state == FILL);
  assign w_last        = w_accept && (r_beat_cnt == BCW'(LINE_BEATS - 1));
  assign w_clear       = i_fetch_start || i_flush || w_halt_det;

  assign w_ent0 = '{pc: r_wr_pc,                      instr: i_bus_resp[INSTR_W-1:0]};
  assign w_ent1 = '{pc: r_wr_pc + 64'(INSTR_BYTES),   instr: i_bus_resp[2*INSTR_W-1:INSTR_W]};

  instr_fifo_2w1r #(.DEPTH(DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clear (w_clear),
    .i_push0 (w_accept && !r_skip_low),
    .i_ent0  (w_ent0),
    .i_push1 (w_accept),
    .i_ent1  (w_ent1),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count),
    .o_free  (w_free)
  );

  always_comb begin
    w_state_nxt = r_state;
    if (i_fetch_start)   w_state_nxt = FILL;
    else if (i_flush)    w_state_nxt = IDLE;
    else if (w_halt_det) w_state_nxt = HALT;
    else if (w_last)     w_state_nxt = IDLE;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= IDLE;
      r_wr_pc     <= '0;
      r_skip_low  <= 1'b0;
      r_beat_cnt  <= '0;
      r_halt      <= 1'b0;
      r_line_done <= 1'b0;
      r_out_en    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_out_en    <= 1'b1;
      r_line_done <= w_last && !w_clear;
      if (i_fetch_start) begin
        r_wr_pc    <= {i_fetch_addr[63:3], 3'b000};
        r_skip_low <= i_fetch_addr[2];
        r_beat_cnt <= '0;
        r_halt     <= 1'b0;
      end else begin
        if (w_accept) begin
          r_wr_pc    <= r_wr_pc + 64'(BEAT_BYTES);
          r_skip_low <= 1'b0;
          r_beat_cnt <= r_beat_cnt + 1'b1;
        end
        if (w_halt_det) r_halt <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fetch_instr_queue.sv
// Scoreboard bench: line-level reference model feeds an expected queue, a monitor checks decode output.
module tb_fetch_instr_queue;
  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_start, flush, bus_respcyc, decode_ready;
  logic [63:0] fetch_addr, bus_resp;
  logic        bus_respack, instr_valid, line_done, halt;
  logic [31:0] instr;
  logic [63:0] instr_pc;

  always #5 clk = ~clk;

  fetch_instr_queue #(.BUS_DATA_WIDTH(64), .DEPTH(8), .LINE_BEATS(8)) dut (
    .i_clk(clk), .i_reset(reset), .i_fetch_start(fetch_start), .i_fetch_addr(fetch_addr),
    .i_flush(flush), .i_bus_respcyc(bus_respcyc), .i_bus_resp(bus_resp),
    .o_bus_respack(bus_respack), .o_instr_valid(instr_valid), .o_instr(instr),
    .o_instr_pc(instr_pc), .i_decode_ready(decode_ready), .o_line_done(line_done), .o_halt(halt)
  );

  int checks = 0, errors = 0;
  int cyc = 0, ld_cyc = -1;
  logic [31:0] exp_i[$];
  logic [63:0] exp_pc[$];
  bit          m_fill, m_skip, m_halt;
  logic [63:0] m_pc;
  int          m_beats;
  bit          rnd_ready_en = 1'b0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endfunction

  always @(posedge clk) cyc++;

  always @(posedge clk) if (rnd_ready_en) begin
    #1 decode_ready = 1'($urandom_range(0, 1));
  end

  // Monitor: pops the expected stream on every handshake, checks line_done each cycle.
  always @(negedge clk) begin
    if (!reset) begin
      chk("line_done", line_done, 64'(cyc == ld_cyc));
      if (instr_valid && decode_ready) begin
        if (exp_i.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_instr actual=%h pc=%h required=none", instr, instr_pc);
        end else begin
          chk("instr", instr, exp_i.pop_front());
          chk("instr_pc", instr_pc, exp_pc.pop_front());
        end
      end
    end
  end

  function automatic void model_clear();
    exp_i.delete(); exp_pc.delete();
    m_fill = 0; m_halt = 0; ld_cyc = -1;
  endfunction

  function automatic void model_word(logic [31:0] w, logic [63:0] pc);
    if (m_halt) return;
    if (w == 32'h0) m_halt = 1;
    else begin exp_i.push_back(w); exp_pc.push_back(pc); end
  endfunction

  // Line-level rule: word j of the line sits at aligned_base + 4*j; a set bit 2 drops word 0.
  function automatic void model_accept(logic [63:0] d);
    if (!m_fill) return;
    m_beats++;
    if (!m_skip) model_word(d[31:0], m_pc);
    model_word(d[63:32], m_pc + 64'd4);
    m_skip = 0;
    m_pc = m_pc + 64'd8;
    if (m_beats == 8) begin
      m_fill = 0;
      if (!m_halt) ld_cyc = cyc + 1;
    end
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_line(input logic [63:0] addr, input bit with_flush);
    fetch_start = 1; fetch_addr = addr; flush = with_flush;
    tick();
    fetch_start = 0; flush = 0;
    model_clear();
    m_fill = 1; m_pc = {addr[63:3], 3'b000}; m_skip = addr[2]; m_beats = 0;
  endtask

  task automatic flush_pulse();
    flush = 1;
    tick();
    flush = 0;
    model_clear();
  endtask

  task automatic send_beat(input logic [63:0] d, output int waits);
    bit acked = 0;
    bus_respcyc = 1; bus_resp = d; waits = 0;
    while (!acked && waits < 200) begin
      @(negedge clk);
      if (bus_respack) acked = 1; else waits++;
    end
    if (acked) model_accept(d);
    else begin checks++; errors++; $display("FAIL beat_ack_timeout actual=no_ack required=ack"); end
    tick();
    bus_respcyc = 0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 500 && exp_i.size() != 0; i++) @(negedge clk);
    chk("drain_left", 64'(exp_i.size()), 64'd0);
    tick();
  endtask

  // Holds a beat on the bus across reset release: masked one cycle, then drained.
  task automatic reset_release_check();
    bus_respcyc = 1; bus_resp = 64'h1111_2222_3333_4444;
    @(negedge clk);
    chk("rst_respack", bus_respack, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_halt", halt, 0);
    chk("rst_line_done", line_done, 0);
    tick();
    reset = 0;
    @(negedge clk);
    chk("first_cycle_respack", bus_respack, 0);
    tick();
    @(negedge clk);
    chk("idle_drain_respack", bus_respack, 1);
    chk("idle_valid", instr_valid, 0);
    tick();
    bus_respcyc = 0;
  endtask

  initial begin
    int w;
    logic [63:0] d;
    reset = 1; fetch_start = 0; flush = 0; fetch_addr = '0; bus_respcyc = 0;
    bus_resp = '0; decode_ready = 1;
    model_clear();
    reset_release_check();

    // Basic aligned line
    start_line(64'h1000, 0);
    for (int k = 0; k < 8; k++) send_beat({32'(k*2+2), 32'(k*2+1)}, w);
    wait_drain();
    chk("basic_halt", halt, 0);

    // Unaligned start skips the low word of the first beat
    start_line(64'h1004, 0);
    send_beat(64'hBBBB_BBBB_AAAA_AAAA, w);
    for (int k = 1; k < 8; k++) send_beat({$urandom | 32'h1, $urandom | 32'h1}, w);
    wait_drain();

    // Back-pressure: four beats fill the queue, the fifth stalls
    decode_ready = 0;
    start_line(64'h2000, 0);
    for (int k = 0; k < 4; k++) begin
      send_beat({32'(k*2+2), 32'(k*2+1)}, w);
      chk("bp_prompt_ack", 64'(w), 64'd0);
    end
    bus_respcyc = 1; bus_resp = {32'd10, 32'd9};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_stall_respack", bus_respack, 0);
    end
    tick();
    decode_ready = 1;
    for (int k = 4; k < 8; k++) send_beat({32'(k*2+2), 32'(k*2+1)}, w);
    wait_drain();

    // Halt on a zero low word in beat 3
    start_line(64'h3000, 0);
    for (int k = 1; k <= 8; k++) begin
      d = (k == 3) ? {32'h6, 32'h0} : {32'(2*k), 32'(2*k-1)};
      send_beat(d, w);
    end
    wait_drain();
    repeat (3) tick();
    chk("halt_set", halt, 1);
    chk("halt_valid", instr_valid, 0);
    send_beat(64'h5555_6666_7777_8888, w);
    chk("halt_drain_ack", 64'(w), 64'd0);
    chk("halt_sticky", halt, 1);
    start_line(64'h3100, 0);
    chk("halt_cleared", halt, 0);

    // Flush mid-line
    decode_ready = 0;
    start_line(64'h4000, 0);
    send_beat({32'h2, 32'h1}, w);
    send_beat({32'h4, 32'h3}, w);
    flush_pulse();
    chk("flush_valid", instr_valid, 0);
    for (int k = 3; k <= 8; k++) begin
      send_beat({$urandom | 32'h1, $urandom | 32'h1}, w);
      chk("flush_drain_ack", 64'(w), 64'd0);
    end
    start_line(64'h5000, 1);
    chk("start_flush_valid", instr_valid, 0);
    send_beat({32'hCAFE_0002, 32'hCAFE_0001}, w);
    decode_ready = 1;
    wait_drain();

    // Async reset between edges, mid-burst
    decode_ready = 0;
    start_line(64'h6000, 0);
    send_beat({32'h2, 32'h1}, w);
    send_beat({32'h4, 32'h3}, w);
    bus_respcyc = 1; bus_resp = {32'h6, 32'h5};
    @(posedge clk); #3;
    reset = 1;
    #1;
    chk("async_respack", bus_respack, 0);
    chk("async_valid", instr_valid, 0);
    chk("async_instr", instr, 0);
    chk("async_pc", instr_pc, 0);
    chk("async_halt", halt, 0);
    chk("async_line_done", line_done, 0);
    model_clear();
    decode_ready = 1;
    reset_release_check();
    repeat (3) tick();

    // Randomized lines with random decode back-pressure
    rnd_ready_en = 1;
    for (int l = 0; l < 4; l++) begin
      start_line({$urandom, $urandom}, 0);
      for (int k = 0; k < 8; k++) send_beat({$urandom | 32'h1, $urandom | 32'h1}, w);
      wait_drain();
    end
    rnd_ready_en = 0;
    tick();
    decode_ready = 1;
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_instr_queue.md
Name: fetch_instr_queue

Overview:
- Sits directly downstream of the top-level fetch FSM's bus read and upstream of decode.
- Consumes the 64-bit Sysbus response beats of one instruction-line fetch and splits each beat into two 32-bit instructions, low word first.
- Queues the instructions with their PCs and presents them one per cycle to decode over a valid/ready handshake.
- Detects an all-zero instruction word and raises a sticky halt.

Parameters:
- BUS_DATA_WIDTH, 64, Sysbus data width; the block is defined only for 64.
- DEPTH, 8, instruction queue entries; a power of 2, and at least 2.
- LINE_BEATS, 8, response beats per fetched line (64-byte line).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- fetch_start  in  1  one-cycle pulse: a new line read was issued at fetch_addr
- fetch_addr  in  64  byte address of the first instruction wanted
- flush  in  1  discard the queue and any remaining beats of the current line
- bus_respcyc  in  1  response beat valid
- bus_resp  in  BUS_DATA_WIDTH  response beat data
- bus_respack  out  1  beat accepted/consumed (combinational)
- instr_valid  out  1  head instruction valid
- instr  out  32  head instruction
- instr_pc  out  64  PC of the head instruction
- decode_ready  in  1  decode accepts the head this cycle
- line_done  out  1  one-cycle pulse after the last beat of a line is accepted
- halt  out  1  sticky: a zero instruction reached the head

Behaviour:
- Reset (async) behaviour:
  - state=IDLE; queue empty; beat count 0.
  - All outputs are 0 while reset is high and in the first cycle after release.
- States: IDLE, FILL, HALT.
  - IDLE and HALT: any bus_respcyc beat is acked (bus_respack=1) and discarded, so that bursts drain.
  - FILL: beats are stored.
- Transitions:
  - fetch_start from any state → FILL. Same edge: clear the queue, set beat count 0, clear halt, load wr_pc={fetch_addr[63:3],3'b0}, set skip_low=fetch_addr[2].
  - flush (without fetch_start) → IDLE; clear the queue. halt is unchanged.
  - FILL → IDLE on acceptance of beat number LINE_BEATS; line_done pulses the next cycle.
  - Head instruction == 32'h0 while not HALT → HALT next edge. Clear the queue, set halt=1. The zero word is never presented.
- fetch_start and flush in the same cycle: fetch_start wins. The net result is an empty queue in FILL.
- Beat accept in FILL: bus_respack = bus_respcyc && (free entries >= 2). The beat is accepted on that edge.
  - Push bus_resp[31:0] with pc=wr_pc, then bus_resp[63:32] with pc=wr_pc+4. wr_pc += 8.
  - On the first beat with skip_low=1, push only the high word; skip_low then clears. That beat needs only 1 free entry.
  - The beat counter increments on every accepted beat in FILL, whether one or two words were pushed.
- Output side:
  - instr_valid = queue non-empty && head != 0 && state != HALT.
  - Pop on instr_valid && decode_ready.
  - Push and pop in the same cycle are both performed; occupancy is computed from the pre-edge count.
  - Full accept is allowed when free entries plus the concurrent pop reach 2 or more, i.e. ack may depend on decode_ready.
- Width rules:
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - The count is log2(DEPTH)+1 bits.
  - PC arithmetic is 64-bit modulo 2^64.
- The queue is never over-run and never under-run.
- Reset mid-line: all state is lost; any outstanding beats after release are acked and dropped (IDLE).

Decomposition:
- Package fetch_pkg holds:
  - the fetch_q_state_t enum {IDLE, FILL, HALT};
  - INSTR_W=32;
  - INSTR_BYTES=4;
  - BEAT_BYTES=8;
  - the halt-word constant 32'h0.
- One sub-module, instr_fifo_2w1r:
  - DEPTH-entry circular buffer of {pc,instr};
  - push0/push1/pop ports;
  - count and free outputs.

Test Plan:
1. Basic line: reset, fetch_start with fetch_addr=0x1000, 8 beats where beat k={32'h(k*2+2),32'h(k*2+1)}, decode_ready=1.
   - Expect 16 instructions 0x1..0x10 with PCs 0x1000..0x103C in order.
   - Expect line_done one cycle after the 8th ack.
   - halt stays 0.
2. Unaligned start: fetch_addr=0x1004; first beat 0xBBBB_BBBB_AAAA_AAAA.
   - First instr=0xBBBBBBBB at pc 0x1004; 0xAAAAAAAA is never presented.
   - Subsequent PCs continue at 0x1008.
3. Back-pressure: decode_ready=0, 8 beats offered back-to-back.
   - Exactly 4 beats acked (queue full at 8), then bus_respack=0.
   - Raise decode_ready: the remaining beats are accepted and all 16 instructions arrive in order with none lost.
4. Halt: beat 3 low word = 0.
   - Instructions before it are delivered.
   - halt=1 one cycle after the zero reaches the head; instr_valid=0 thereafter.
   - The remaining beats are still acked.
   - A new fetch_start clears halt.
5. Flush mid-line: flush after beat 2.
   - The queue empties next cycle.
   - Beats 3-8 are acked and discarded; no instr_valid and no line_done.
   - fetch_start+flush in the same cycle: state=FILL and the queue is empty.
6. Async reset asserted mid-burst between clock edges: all outputs drop immediately, the queue is empty, state=IDLE, and a later beat is acked and dropped.
